regfile_debug_arbiter: RTL
==========================

REGFILE_DEBUG_ARBITER -- requirements
Module: regfile_debug_arbiter

Interface
REQ-001 Parameter SETTLE, default 1: number of core-stall cycles before debug access (legal 1..7).
REQ-002 Parameter DATA_W, default 32: register data width.
REQ-003 Parameter ADDR_W, default 5: register address width.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, with these ports:
  CLK  in  1  clock; all state updates on rising edge.
  reset  in  1  synchronous, active-low reset.
  core_A1  in  ADDR_W  core read-port-1 address.
  core_A3  in  ADDR_W  core write address.
  core_WD3  in  DATA_W  core write data.
  core_WE3  in  1  core write enable.
  core_stall  out  1  core halt request; core holds PC and suppresses its own side effects while high.
  rf_A1  out  ADDR_W  register file A1.
  rf_A3  out  ADDR_W  register file A3.
  rf_WD3  out  DATA_W  register file WD3.
  rf_WE3  out  1  register file WE3.
  rf_RD1  in  DATA_W  register file RD1, combinational from rf_A1.
  dbg_valid  in  1  debug request valid.
  dbg_wr  in  1  1 = write, 0 = read.
  dbg_addr  in  ADDR_W  debug register address.
  dbg_wdata  in  DATA_W  debug write data.
  dbg_ready  out  1  request accepted this cycle.
  dbg_rvalid  out  1  one-cycle completion pulse, for reads and writes.
  dbg_rdata  out  DATA_W  registered read data; valid while dbg_rvalid is high, held afterwards.

Function
REQ-005 FSM states SHALL be IDLE, STALL, ACCESS, RESP.
REQ-006 IDLE: core_stall=0; if dbg_valid is high, go to STALL and load the settle counter with SETTLE-1.
REQ-007 STALL: core_stall=1; counter decrements each cycle; go to ACCESS when counter==0.
REQ-008 STALL: if dbg_valid drops, go to IDLE with no register file access; core_stall is 0 on the next cycle.
REQ-009 ACCESS lasts exactly one cycle, with core_stall=1, dbg_ready=1 and rf_A1=dbg_addr.
REQ-010 ACCESS, write: rf_A3=dbg_addr, rf_WD3=dbg_wdata, rf_WE3=1.
REQ-011 ACCESS, read: rf_WE3=0, and dbg_rdata captures rf_RD1 at the closing edge.
REQ-012 ACCESS, debug write to address 0: rf_WE3 forced 0, but the handshake completes normally.
REQ-013 RESP lasts exactly one cycle, with dbg_rvalid=1 and core_stall=0, then goes to IDLE.
REQ-014 In IDLE, STALL and RESP, rf_A1/rf_A3/rf_WD3/rf_WE3 SHALL pass core_A1/core_A3/core_WD3/core_WE3 combinationally; core writes issued in the first STALL cycle reach the register file.
REQ-015 Latency with SETTLE=1: dbg_valid seen in IDLE at edge k gives STALL in cycle k+1, ACCESS in k+2 and dbg_rvalid in k+3; in general, ACCESS starts SETTLE+1 cycles after acceptance into STALL.
REQ-016 A new request is not sampled in RESP; back-to-back requests SHALL therefore be separated by at least one IDLE cycle.
REQ-017 dbg_wr, dbg_addr and dbg_wdata SHALL be sampled only during ACCESS; changes in STALL are legal.
REQ-018 dbg_ready and dbg_rvalid SHALL never be high in the same cycle.

Reset
REQ-019 While reset=0 at a rising edge: state=IDLE, counter=0, dbg_rdata=0 and dbg_rvalid=0.
REQ-020 Reset with dbg_ready=0 and core_stall=0 SHALL result in pass-through muxing on the following cycle.
REQ-021 Reset asserted during STALL or ACCESS SHALL abort the access: no debug write lands after that edge, and no dbg_rvalid is produced.

Structure
REQ-022 FSM state encoding and default parameter constants SHALL live in a shared package, regfile_dbg_pkg.
REQ-023 The settle counter SHALL be one sub-module, stall_settle_counter (load, decrement, zero flag).
REQ-024 The register file itself SHALL stay external; this block only muxes its A1/A3/WD3/WE3 ports.

Verification
REQ-025 Debug write: SETTLE=1, dbg_valid=1, dbg_wr=1, dbg_addr=7, dbg_wdata=0x0000_00A5 -> rf_WE3=1 with A3=7 in cycle k+2; later core read of x7 returns 0x0000_00A5; dbg_rvalid in k+3.
REQ-026 Debug read: preload x3=0x1234_5678, then read addr 3 -> dbg_rdata=0x1234_5678 with dbg_rvalid=1 in k+3; core_stall high exactly cycles k+1..k+2.
REQ-027 Address 0: debug write 0xFFFF_FFFF to addr 0 -> rf_WE3 stays 0, handshake completes, subsequent read of x0 returns 0.
REQ-028 Abort: SETTLE=4, dbg_valid dropped in 2nd STALL cycle -> IDLE next cycle, no dbg_ready, no rf write, core_stall=0.
REQ-029 Reset mid-access: reset=0 during ACCESS of write 0x55 to x9 -> x9 unchanged, dbg_rvalid never asserted, core_stall=0 after the edge.
REQ-030 Overlap: core_WE3=1 writing x5=0x11 in first STALL cycle while debug writes x6=0x22 -> both registers hold their values; pass-through is restored in RESP.

Source files
------------

// File: rtl/regfile_dbg_pkg.sv
// Shared definitions for the register-file debug arbiter: FSM encoding,
// default parameter values and the settle-counter load helper.
package regfile_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STALL  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } dbg_state_e;

  localparam int unsigned SETTLE_DEFAULT = 32'd1;
  localparam int unsigned DATA_W_DEFAULT = 32'd32;
  localparam int unsigned ADDR_W_DEFAULT = 32'd5;
  localparam int unsigned CNT_W          = 32'd3;

  // The counter counts down to zero, so SETTLE stall cycles need SETTLE-1 loaded.
  function automatic logic [CNT_W-1:0] settle_load(input int unsigned settle);
    return CNT_W'(settle - 32'd1);
  endfunction

endpackage

// File: rtl/stall_settle_counter.sv
// Down-counter that times the core-stall settle window before a debug access.
module stall_settle_counter
  import regfile_dbg_pkg::*;
(
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/regfile_debug_arbiter.sv
// Steals the register-file ports from the core for one debug read or write,
// stalling the core for a settle window first and handing the ports back after.
module regfile_debug_arbiter
  import regfile_dbg_pkg::*;
#(
  parameter int unsigned SETTLE = SETTLE_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] core_A1,
  input  logic [ADDR_W-1:0] core_A3,
  input  logic [DATA_W-1:0] core_WD3,
  input  logic              core_WE3,
  output logic              core_stall,
  output logic [ADDR_W-1:0] rf_A1,
  output logic [ADDR_W-1:0] rf_A3,
  output logic [DATA_W-1:0] rf_WD3,
  output logic              rf_WE3,
  input  logic [DATA_W-1:0] rf_RD1,
  input  logic              dbg_valid,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata
);

  dbg_state_e        state_q;
  dbg_state_e        state_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              rvalid_q;
  logic              rvalid_d;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              in_access;

  stall_settle_counter u_settle (
    .CLK      (CLK),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (settle_load(SETTLE)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // A dropped request during the settle window abandons it without touching the file.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dbg_valid) begin
          state_d  = ST_STALL;
          cnt_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STALL: begin
        if (!dbg_valid) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_STALL;
          cnt_dec = 1'b1;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Gating with reset keeps a debug write from landing on the aborting edge.
  assign in_access  = (state_q == ST_ACCESS) && reset;
  assign core_stall = (state_q == ST_STALL) || (state_q == ST_ACCESS);
  assign dbg_ready  = in_access;

  always_comb begin
    rf_A1  = core_A1;
    rf_A3  = core_A3;
    rf_WD3 = core_WD3;
    rf_WE3 = core_WE3;
    if (state_q == ST_ACCESS) begin
      rf_A1  = dbg_addr;
      rf_A3  = dbg_addr;
      rf_WD3 = dbg_wdata;
      rf_WE3 = in_access && dbg_wr && (dbg_addr != {ADDR_W{1'b0}});
    end else begin
      rf_A1  = core_A1;
      rf_A3  = core_A3;
      rf_WD3 = core_WD3;
      rf_WE3 = core_WE3;
    end
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = (state_q == ST_ACCESS);
    if ((state_q == ST_ACCESS) && !dbg_wr) begin
      rdata_d = rf_RD1;
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rdata_q  <= {DATA_W{1'b0}};
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign dbg_rvalid = rvalid_q;
  assign dbg_rdata  = rdata_q;

endmodule
